// File: rtl/proc_control_if.sv
// Control/datapath link for the 9-bit processor: instruction/start in, control strobes out.
// Latency: wires only; no storage in the interface.
// Backpressure: none; Run is a level request sampled only by the controller in T0.
interface proc_control_if;
    logic       Run;
    logic [8:0] Din;
    logic       R0in, R1in, R2in, R3in, R4in, R5in, R6in, R7in;
    logic       Ain;
    logic       Gin;
    logic       R0out, R1out, R2out, R3out, R4out, R5out, R6out, R7out;
    logic       Gout;
    logic       Dinout;
    logic       AddSub;
    logic       Done;

    // Controller side: takes the request and instruction, drives every datapath strobe.
    modport master (
        input  Run, Din,
        output R0in, R1in, R2in, R3in, R4in, R5in, R6in, R7in, Ain, Gin,
        output R0out, R1out, R2out, R3out, R4out, R5out, R6out, R7out, Gout, Dinout,
        output AddSub, Done
    );

    // Datapath / requester side.
    modport slave (
        output Run, Din,
        input  R0in, R1in, R2in, R3in, R4in, R5in, R6in, R7in, Ain, Gin,
        input  R0out, R1out, R2out, R3out, R4out, R5out, R6out, R7out, Gout, Dinout,
        input  AddSub, Done
    );
endinterface

// File: rtl/proc_control.sv
// Control FSM for the 9-bit processor: fetches IR on Run, sequences register/adder strobes.
// Latency: Done in T1 for mv/mvi/NOP, in T3 for add/sub; one T0 cycle between instructions.
// Backpressure: none; Run is ignored outside T0, all outputs are decodes of (state, IR).
module proc_control (
    input  logic           clk,
    input  logic           rst,
    proc_control_if.master cif
);
    typedef enum logic [1:0] {T0, T1, T2, T3} state_t;

    state_t     state_q, state_d;
    logic [8:0] ir_q, ir_d;
    logic [2:0] op, rx, ry;
    logic [7:0] r_in, r_out;
    logic       ain, gin, gout, dinout, addsub, done;

    assign op = ir_q[8:6];
    assign rx = ir_q[5:3];
    assign ry = ir_q[2:0];

    // State and instruction register; reset aborts any instruction in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= T0;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
        end
    end

    // Next-state and control decode; only one bus driver is ever selected per step.
    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        r_in    = '0;
        r_out   = '0;
        ain     = 1'b0;
        gin     = 1'b0;
        gout    = 1'b0;
        dinout  = 1'b0;
        addsub  = 1'b0;
        done    = 1'b0;
        case (state_q)
            T0: begin
                if (cif.Run) begin
                    ir_d    = cif.Din;
                    state_d = T1;
                end
            end
            T1: begin
                case (op)
                    3'b000: begin           // mv Rx,Ry
                        r_out[ry] = 1'b1;
                        r_in[rx]  = 1'b1;
                        done      = 1'b1;
                        state_d   = T0;
                    end
                    3'b001: begin           // mvi Rx,#D (immediate on Din this cycle)
                        dinout    = 1'b1;
                        r_in[rx]  = 1'b1;
                        done      = 1'b1;
                        state_d   = T0;
                    end
                    3'b010, 3'b011: begin   // add/sub: first operand into A
                        r_out[rx] = 1'b1;
                        ain       = 1'b1;
                        state_d   = T2;
                    end
                    default: begin          // reserved opcodes complete as NOP
                        done      = 1'b1;
                        state_d   = T0;
                    end
                endcase
            end
            T2: begin                       // second operand through the adder into G
                r_out[ry] = 1'b1;
                gin       = 1'b1;
                addsub    = op[0];
                state_d   = T3;
            end
            T3: begin                       // result from G back into Rx
                gout      = 1'b1;
                r_in[rx]  = 1'b1;
                done      = 1'b1;
                state_d   = T0;
            end
        endcase
    end

    assign cif.R0in   = r_in[0];
    assign cif.R1in   = r_in[1];
    assign cif.R2in   = r_in[2];
    assign cif.R3in   = r_in[3];
    assign cif.R4in   = r_in[4];
    assign cif.R5in   = r_in[5];
    assign cif.R6in   = r_in[6];
    assign cif.R7in   = r_in[7];
    assign cif.R0out  = r_out[0];
    assign cif.R1out  = r_out[1];
    assign cif.R2out  = r_out[2];
    assign cif.R3out  = r_out[3];
    assign cif.R4out  = r_out[4];
    assign cif.R5out  = r_out[5];
    assign cif.R6out  = r_out[6];
    assign cif.R7out  = r_out[7];
    assign cif.Ain    = ain;
    assign cif.Gin    = gin;
    assign cif.Gout   = gout;
    assign cif.Dinout = dinout;
    assign cif.AddSub = addsub;
    assign cif.Done   = done;
endmodule

// File: tb/tb_proc_control.sv
// Directed bench for proc_control with a small behavioural datapath attached.
// Latency: checks once per cycle on the falling edge, inputs changed there too.
// Backpressure: n/a; Run/Din driven directly.
module tb_proc_control;
    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_bad = 0;

    proc_control_if cif ();

    proc_control dut (
        .clk (clk),
        .rst (rst),
        .cif (cif.master)
    );

    always #5 clk = ~clk;

    // Packed view of all outputs: {Rin[7:0], Ain, Gin, Rout[7:0], Gout, Dinout, AddSub, Done}
    logic [7:0]  rin, rout;
    logic [21:0] obs;
    assign rin  = {cif.R7in, cif.R6in, cif.R5in, cif.R4in, cif.R3in, cif.R2in, cif.R1in, cif.R0in};
    assign rout = {cif.R7out, cif.R6out, cif.R5out, cif.R4out, cif.R3out, cif.R2out, cif.R1out, cif.R0out};
    assign obs  = {rin, cif.Ain, cif.Gin, rout, cif.Gout, cif.Dinout, cif.AddSub, cif.Done};

    // Behavioural datapath driven by the controller strobes.
    logic [8:0] R [8];
    logic [8:0] A, G, bus;

    always_comb begin
        bus = '0;
        for (int i = 0; i < 8; i++) if (rout[i]) bus = R[i];
        if (cif.Gout)   bus = G;
        if (cif.Dinout) bus = cif.Din;
    end

    always @(posedge clk) begin
        if (cif.Ain) A <= bus;
        if (cif.Gin) G <= cif.AddSub ? (A - bus) : (A + bus);
        for (int i = 0; i < 8; i++) if (rin[i]) R[i] <= bus;
    end

    function automatic logic [7:0] oh(input logic [2:0] n);
        logic [7:0] v;
        v = 8'd1 << n;
        return v;
    endfunction

    function automatic logic [21:0] ov(input logic [7:0] ri, input logic ai, input logic gi,
                                       input logic [7:0] ro, input logic go, input logic di,
                                       input logic as, input logic dn);
        return {ri, ai, gi, ro, go, di, as, dn};
    endfunction

    task automatic chk(input string tag, input logic [21:0] got, input logic [21:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    // mvi Rx,#v: fetch, T1 strobes, back to T0, register loaded.
    task automatic do_mvi(input logic [2:0] x, input logic [8:0] v);
        cif.Run = 1'b1;
        cif.Din = {3'b001, x, 3'b000};
        cyc();
        chk("mvi_t1", obs, ov(oh(x), 0, 0, 8'h00, 0, 1, 0, 1));
        cif.Run = 1'b0;
        cif.Din = v;
        cyc();
        chk("mvi_t0", obs, '0);
        chk("mvi_reg", {13'd0, R[x]}, {13'd0, v});
    endtask

    initial begin
        rst     = 1'b1;
        cif.Run = 1'b1;
        cif.Din = 9'b010_001_010;
        cyc();
        cyc();
        chk("reset_outs", obs, '0);
        rst     = 1'b0;
        cif.Run = 1'b0;
        cyc();
        chk("idle_hold", obs, '0);

        // mvi R0,#5 then load operands
        do_mvi(3'd0, 9'h005);
        do_mvi(3'd1, 9'd3);
        do_mvi(3'd2, 9'd9);

        // mv R3,R0
        cif.Run = 1'b1;
        cif.Din = 9'b000_011_000;
        cyc();
        chk("mv_t1", obs, ov(oh(3), 0, 0, oh(0), 0, 0, 0, 1));
        cif.Run = 1'b0;
        cyc();
        chk("mv_t0", obs, '0);
        chk("mv_r3", {13'd0, R[3]}, 22'd5);

        // mv R5,R5 (same source and destination)
        do_mvi(3'd5, 9'h123);
        cif.Run = 1'b1;
        cif.Din = 9'b000_101_101;
        cyc();
        chk("mvself_t1", obs, ov(oh(5), 0, 0, oh(5), 0, 0, 0, 1));
        cif.Run = 1'b0;
        cyc();
        chk("mvself_r5", {13'd0, R[5]}, 22'h123);

        // add R1,R2 : 3 + 9 = 12
        cif.Run = 1'b1;
        cif.Din = 9'b010_001_010;
        cyc();
        chk("add_t1", obs, ov(8'h00, 1, 0, oh(1), 0, 0, 0, 0));
        cif.Run = 1'b0;
        cyc();
        chk("add_t2", obs, ov(8'h00, 0, 1, oh(2), 0, 0, 0, 0));
        cyc();
        chk("add_t3", obs, ov(oh(1), 0, 0, 8'h00, 1, 0, 0, 1));
        cyc();
        chk("add_t0", obs, '0);
        chk("add_r1", {13'd0, R[1]}, 22'd12);

        // sub R1,R2 : 3 - 9 = -6 mod 512
        do_mvi(3'd1, 9'd3);
        cif.Run = 1'b1;
        cif.Din = 9'b011_001_010;
        cyc();
        chk("sub_t1", obs, ov(8'h00, 1, 0, oh(1), 0, 0, 0, 0));
        cif.Run = 1'b0;
        cyc();
        chk("sub_t2", obs, ov(8'h00, 0, 1, oh(2), 0, 0, 1, 0));
        cyc();
        chk("sub_t3", obs, ov(oh(1), 0, 0, 8'h00, 1, 0, 0, 1));
        cyc();
        chk("sub_r1", {13'd0, R[1]}, 22'h1FA);

        // Back-to-back with Run held: add R1,R2 then mvi R4; Din changes mid-add
        do_mvi(3'd1, 9'd3);
        cif.Run = 1'b1;
        cif.Din = 9'b010_001_010;
        cyc();
        chk("b2b_t1", obs, ov(8'h00, 1, 0, oh(1), 0, 0, 0, 0));
        cif.Din = 9'b001_100_000;
        cyc();
        chk("b2b_t2", obs, ov(8'h00, 0, 1, oh(2), 0, 0, 0, 0));
        cyc();
        chk("b2b_t3", obs, ov(oh(1), 0, 0, 8'h00, 1, 0, 0, 1));
        cyc();
        chk("b2b_t0", obs, '0);
        cyc();
        chk("b2b_mvi_t1", obs, ov(oh(4), 0, 0, 8'h00, 0, 1, 0, 1));
        cif.Run = 1'b0;
        cif.Din = 9'h0AA;
        cyc();
        chk("b2b_end", obs, '0);
        chk("b2b_r1", {13'd0, R[1]}, 22'd12);
        chk("b2b_r4", {13'd0, R[4]}, 22'h0AA);

        // Reset during T2 of add R1,R2: abort, R1 untouched
        do_mvi(3'd1, 9'd3);
        cif.Run = 1'b1;
        cif.Din = 9'b010_001_010;
        cyc();
        cif.Run = 1'b0;
        cyc();
        chk("rst_pre_t2", obs, ov(8'h00, 0, 1, oh(2), 0, 0, 0, 0));
        rst     = 1'b1;
        cif.Run = 1'b1;
        cyc();
        chk("rst_mid_outs", obs, '0);
        rst     = 1'b0;
        cif.Run = 1'b0;
        cyc();
        chk("rst_after_outs", obs, '0);
        chk("rst_r1", {13'd0, R[1]}, 22'd3);

        // Reserved opcode 111: Done only
        cif.Run = 1'b1;
        cif.Din = 9'b111_010_011;
        cyc();
        chk("nop_t1", obs, ov(8'h00, 0, 0, 8'h00, 0, 0, 0, 1));
        cif.Run = 1'b0;
        cyc();
        chk("nop_t0", obs, '0);
        chk("nop_r2", {13'd0, R[2]}, 22'd9);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
